serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial adder controller: sequences a single 1-bit full_adder over WIDTH cycles to add
//  two WIDTH-bit operands plus carry-in, LSB first. Trades WIDTH cycles of latency for one
//  adder cell. Sits between an operand source using a start/done handshake and the 1-bit
//  adder datapath.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  clk    in   1      single clock, all state updates on rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  operand A, captured on accepted start
//  b      in   WIDTH  operand B, captured on accepted start
//  cin    in   1      carry-in, captured on accepted start
//  busy   out  1      high while RUN (addition in progress)
//  done   out  1      one-cycle pulse; result valid
//  sum    out  WIDTH  result register
//  cout   out  1      final carry-out register
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift regs,
//    carry FF and counter = 0. Reset takes priority over every other condition.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE: start=1 -> load opA<=a, opB<=b, carry<=cin, cnt<=0, part<=0; go RUN. start=0 -> stay.
//    RUN: each cycle full_adder(opA[0], opB[0], carry) -> s, c. part <= {s, part[WIDTH-1:1]};
//      opA, opB shift right 1 (zero fill); carry <= c; cnt <= cnt+1.
//      When cnt==WIDTH-1 this cycle: sum <= {s, part[WIDTH-1:1]}, cout <= c, go DONE.
//    DONE: done=1 for exactly this cycle; go IDLE unconditionally.
//  - Timing: start accepted at edge k -> busy high cycles k+1..k+WIDTH (WIDTH cycles);
//    done high cycle k+WIDTH+1; new start sampled at earliest edge k+WIDTH+2.
//  - busy = (state==RUN); done = (state==DONE). Both decoded from registered state, glitch-free.
//  - sum/cout update only on the final RUN cycle; held stable through DONE and IDLE and during
//    the next operation until its own completion. Never show partial results.
//  - start while RUN or DONE: ignored, no effect on operands or result. No queuing.
//  - a/b/cin changes after acceptance: no effect on the operation in flight.
//  - rst mid-RUN: operation aborted, no done pulse, sum/cout cleared to 0.
//  - Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned; overflow reported only
//    via cout.
//  - cnt width $clog2(WIDTH); counter never wraps (exits RUN at WIDTH-1).
// STRUCTURE
//  - Package serial_adder_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;
//    no other shared constants.
//  - One sub-module: full_adder (a, b, cin -> sum, ca), instantiated once as the datapath cell.
//  - Rest of the block: one always_ff for state/counter/shift regs, combinational next-state
//    logic.
// TESTING (WIDTH=8)
//  1. rst 2 cycles -> busy=0, done=0, sum=8'h00, cout=0; hold start=0 20 cycles -> no change.
//  2. a=8'h3C, b=8'h0F, cin=0, 1-cycle start -> busy 8 cycles; done pulse 9 cycles after
//     start edge; sum=8'h4B, cout=0.
//  3. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; then a=8'hFF, b=8'h00, cin=1 ->
//     sum=8'h00, cout=1.
//  4. start held high continuously with a=8'h01, b=8'h02 -> ops complete every 10 cycles,
//     sum=8'h03; operand change mid-RUN to a=8'hAA -> in-flight result still 8'h03.
//  5. Start a=8'h80, b=8'h80, assert rst at 4th busy cycle -> no done pulse, sum=0, cout=0,
//     state IDLE; next start a=8'h80, b=8'h80 -> sum=8'h00, cout=1.
//  6. Random a/b/cin, 200 ops, scoreboard vs a+b+cin; check busy/done never high together.

Source files
------------

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// serial_adder_pkg : shared FSM state type for the bit-serial adder  | rev 1.0
// ============================================================================
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sa_state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_ctrl_full_adder.sv
`default_nettype none
// ============================================================================
// full_adder : 1-bit full adder cell, the only arithmetic in the datapath | rev 1.0
// ============================================================================
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic ca
);

   logic w_p;

   assign w_p = a ^ b;
   assign sum = w_p ^ cin;
   assign ca  = (a & b) | (cin & w_p);

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// serial_adder_ctrl : LSB-first bit-serial adder, WIDTH cycles per add  | rev 1.0
// ============================================================================
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   import serial_adder_pkg::*;

   localparam int                c_CNT_W = $clog2(WIDTH);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

   sa_state_t          r_state;
   sa_state_t          w_next_state;
   logic [WIDTH-1:0]   r_op_a;
   logic [WIDTH-1:0]   r_op_b;
   logic               r_carry;
   logic [c_CNT_W-1:0] r_cnt;
   // Bit 0 of the partial sum is only ever consumed on the final cycle, so it is not stored.
   logic [WIDTH-2:0]   r_part;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;
   logic               w_s;
   logic               w_c;
   logic               w_last;
   logic [WIDTH-1:0]   w_part_next;

   full_adder u_fa (
      .a   (r_op_a[0]),
      .b   (r_op_b[0]),
      .cin (r_carry),
      .sum (w_s),
      .ca  (w_c)
   );

   assign w_last      = (r_cnt == c_LAST);
   assign w_part_next = {w_s, r_part};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_op_a  <= '0;
         r_op_b  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_part  <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_op_a  <= a;
                  r_op_b  <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  r_part  <= '0;
               end
            end
            RUN: begin
               r_part  <= w_part_next[WIDTH-1:1];
               r_op_a  <= r_op_a >> 1;
               r_op_b  <= r_op_b >> 1;
               r_carry <= w_c;
               if (w_last) begin
                  // Result registers change only here, so no partial value is ever visible.
                  r_sum  <= w_part_next;
                  r_cout <= w_c;
                  r_cnt  <= '0;
               end else begin
                  r_cnt  <= r_cnt + c_CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (start) w_next_state = RUN;
         RUN:     if (w_last) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == RUN);
      done = (r_state == DONE);
   end

   assign sum  = r_sum;
   assign cout = r_cout;

endmodule : serial_adder_ctrl
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// tb_serial_adder_ctrl : vector table, corner sequences, random ops vs a+b+cin | rev 1.0
// ============================================================================
module tb_serial_adder_ctrl;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         co;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         cin;
   logic         busy, done;
   logic [W-1:0] sum;
   logic         cout;

   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] last_sum;
   logic         last_cout;
   vec_t         tbl [8];

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (busy === 1'b1 && done === 1'b1) begin
         n_err++;
         $display("FAIL busy_done_overlap: got busy=1 done=1 expected not both at %0t", $time);
      end
   end

   // One complete operation; inputs are scrambled right after acceptance.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic [W-1:0] es, input logic ec, input string nm);
      int nbusy   = 0;
      int done_at = 0;
      int holdbad = 0;
      @(negedge clk);
      start = 1'b1; a = ta; b = tb_v; cin = tc;
      @(negedge clk);
      start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      for (int n = 1; n <= 12; n++) begin
         if (n > 1) @(negedge clk);
         if (busy) begin
            nbusy++;
            if (sum !== last_sum || cout !== last_cout) holdbad++;
         end
         if (done) begin
            done_at = n;
            break;
         end
      end
      chk({nm, "_busy_cycles"}, nbusy, 8);
      chk({nm, "_done_cycle"}, done_at, 9);
      chk({nm, "_hold"}, holdbad, 0);
      chk({nm, "_sum"}, sum, es);
      chk({nm, "_cout"}, cout, ec);
      last_sum  = es;
      last_cout = ec;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: got no end expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int bad;
      int dones;
      int done_t [$];
      logic [W-1:0] s9, s19, s29;

      tbl[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      tbl[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
      tbl[3] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
      tbl[4] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
      tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      tbl[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      last_sum = '0; last_cout = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      rst = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) bad++;
      end
      chk("idle_no_change", bad, 0);

      for (int i = 0; i < 8; i++)
         do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, $sformatf("tbl%0d", i));

      // start held high: back-to-back ops every 10 cycles; A changes during the second op.
      @(negedge clk);
      start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
      s9 = '0; s19 = '0; s29 = '0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (n == 12) a = 8'hAA;
         if (done) done_t.push_back(n);
         if (n == 9)  s9  = sum;
         if (n == 19) s19 = sum;
         if (n == 29) s29 = sum;
      end
      start = 1'b0;
      chk("b2b_done_count", done_t.size(), 3);
      chk("b2b_done0", (done_t.size() > 0) ? done_t[0] : -1, 9);
      chk("b2b_done1", (done_t.size() > 1) ? done_t[1] : -1, 19);
      chk("b2b_done2", (done_t.size() > 2) ? done_t[2] : -1, 29);
      chk("b2b_sum0", s9, 8'h03);
      chk("b2b_sum1_inflight", s19, 8'h03);
      chk("b2b_sum2", s29, 8'hAC);
      last_sum = 8'hAC; last_cout = 1'b0;

      // Abort mid-run: leave a nonzero result first so the clear is visible.
      do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "pre_abort");
      @(negedge clk);
      start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_before", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_sum", sum, 0);
      chk("abort_cout", cout, 0);
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      chk("abort_no_done", dones, 0);
      last_sum = '0; last_cout = 1'b0;
      do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "after_abort");

      for (int i = 0; i < 200; i++) begin
         logic [W-1:0] ra, rb;
         logic         rc;
         logic [W:0]   tot;
         ra  = W'($urandom);
         rb  = W'($urandom);
         rc  = 1'($urandom);
         tot = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         do_op(ra, rb, rc, tot[W-1:0], tot[W], $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_serial_adder_ctrl
`default_nettype wire
